request_unit_q: RTL

- Parametrised successor to the single-cycle request unit.
- Sits between the datapath's control signals and the memory interface.
- Generates imemREN, and queues data-memory requests raised on ihit in an in-order FIFO of DEPTH entries.
- Presents the FIFO head as dmemREN/dmemWEN and retires it on dhit. Supports overlapped/pipelined issue, halt draining, overflow detection, and an optional watchdog.

---
 rtl/request_unit_q_if.sv | 24 ++
 rtl/request_unit_q.sv | 79 +++++++
 2 files changed

// File: rtl/request_unit_q_if.sv
// request_unit_q_if: datapath-to-memory request bundle; master drives the control side, slave is the request unit
interface request_unit_q_if #(parameter int CNTW = 2);
  logic            halt;
  logic            ihit;
  logic            dhit;
  logic            MemtoReg;
  logic            MemWr;
  logic            imemREN;
  logic            dmemREN;
  logic            dmemWEN;
  logic            full;
  logic            idle;
  logic [CNTW-1:0] count;
  logic            ovf_err;
  logic            timeout_err;
  modport master (
    output halt, ihit, dhit, MemtoReg, MemWr,
    input  imemREN, dmemREN, dmemWEN, full, idle, count, ovf_err, timeout_err
  );
  modport slave (
    input  halt, ihit, dhit, MemtoReg, MemWr,
    output imemREN, dmemREN, dmemWEN, full, idle, count, ovf_err, timeout_err
  );
endinterface

// File: rtl/request_unit_q.sv
// request_unit_q: in-order FIFO of pending data-memory requests behind the instruction fetch request
// Optional head watchdog enabled by defining REQ_TIMEOUT_EN.
module request_unit_q #(
  parameter int DEPTH   = 2,
  parameter int CNTW    = $clog2(DEPTH) + 1,
  parameter int TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RST,
  request_unit_q_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] op_q, op_d;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, idle, enq_req, enq, pop, fire;
  assign full    = count_q == CNTW'(DEPTH);
  assign idle    = count_q == '0;
  assign enq_req = bus.ihit & ~bus.halt & (bus.MemtoReg | bus.MemWr);
  assign pop     = ~idle & (bus.dhit | fire);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign enq     = enq_req & (~full | pop);
  always_comb begin
    op_d          = op_q;
    op_d[wp_q]    = enq ? bus.MemWr : op_q[wp_q];
    wp_d          = wp_q + PW'(enq);
    rp_d          = rp_q + PW'(pop);
    count_d       = count_q + CNTW'(enq) - CNTW'(pop);
    ovf_d         = ovf_q | (enq_req & full & ~pop);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef REQ_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wd_q, wd_d;
  logic          to_q, to_d;
  assign fire = ~idle & ~bus.dhit & (wd_q == WW'(TIMEOUT - 1));
  always_comb begin
    wd_d = (idle | bus.dhit | pop) ? '0 : wd_q + WW'(1);
    to_d = to_q | fire;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
  assign bus.timeout_err = to_q;
`else
  logic unused_timeout;
  assign unused_timeout  = |TIMEOUT;
  assign fire            = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  assign bus.imemREN = ~bus.halt;
  assign bus.dmemREN = ~idle & ~op_q[rp_q];
  assign bus.dmemWEN = ~idle & op_q[rp_q];
  assign bus.full    = full;
  assign bus.idle    = idle;
  assign bus.count   = count_q;
  assign bus.ovf_err = ovf_q;
endmodule
